// File: rtl/pipe_elastic_stage.sv
// Elastic register chain: DEPTH valid/ready stages of WIDTH bits with bubble collapse,
// flush and registered occupancy. Stage 0 faces the producer, stage DEPTH-1 the consumer.

module pipe_elastic_slot #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          CLR_DATA = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             rdy_i,
  input  logic             up_v_i,
  input  logic [WIDTH-1:0] up_d_i,
  output logic             v_d_o,
  output logic             v_q_o,
  output logic [WIDTH-1:0] d_q_o
);
  logic             v_d, v_q;
  logic [WIDTH-1:0] d_d, d_q;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (reset_i || flush_i) begin
      v_d = 1'b0;
      if (CLR_DATA) d_d = '0;
    end else if (rdy_i) begin
      // a ready slot always takes whatever upstream offers, bubble included
      v_d = up_v_i;
      if (up_v_i)        d_d = up_d_i;
      else if (CLR_DATA) d_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    v_q <= v_d;
    d_q <= d_d;
  end

  assign v_d_o = v_d;
  assign v_q_o = v_q;
  assign d_q_o = d_q;
endmodule

module pipe_elastic_stage #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 2,
  parameter bit          CLR_DATA = 1'b1,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CW-1:0]    count_o
);
  logic [DEPTH:0]            rdy;
  logic [DEPTH:0]            vld_pipe;
  logic [DEPTH:0][WIDTH-1:0] dat_pipe;
  logic [DEPTH-1:0]          v_d;
  logic [DEPTH-1:0]          v_q;
  logic [DEPTH-1:0][WIDTH-1:0] d_q;
  logic [CW-1:0]             count_d, count_q;

  // Ready ripples from the consumer back to the producer; an empty slot breaks the stall.
  assign rdy[DEPTH] = out_ready_i;
  assign in_ready_o = rdy[0] & ~flush_i;

  assign vld_pipe = {v_q, in_valid_i & in_ready_o};
  assign dat_pipe = {d_q, in_data_i};

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign rdy[gi] = ~v_q[gi] | rdy[gi+1];

      pipe_elastic_slot #(
        .WIDTH    (WIDTH),
        .CLR_DATA (CLR_DATA)
      ) u_slot (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .rdy_i   (rdy[gi]),
        .up_v_i  (vld_pipe[gi]),
        .up_d_i  (dat_pipe[gi]),
        .v_d_o   (v_d[gi]),
        .v_q_o   (v_q[gi]),
        .d_q_o   (d_q[gi])
      );
    end
  endgenerate

  // Occupancy follows the next-state valids so it lands on the same edge as v[].
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) count_d = count_d + CW'(v_d[i]);
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign out_valid_o = v_q[DEPTH-1];
  assign out_data_o  = d_q[DEPTH-1];
  assign count_o     = count_q;
endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Directed checks of the elastic chain at DEPTH=3 and DEPTH=4, plus a short scoreboard run.

module tb_pipe_elastic_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=3 instance
  logic       a_rst, a_fl, a_iv, a_ir, a_ov, a_or;
  logic [7:0] a_id, a_od;
  logic [1:0] a_cnt;
  // DEPTH=4 instance
  logic       b_rst, b_fl, b_iv, b_ir, b_ov, b_or;
  logic [7:0] b_id, b_od;
  logic [2:0] b_cnt;

  pipe_elastic_stage #(.WIDTH(8), .DEPTH(3), .CLR_DATA(1'b1)) dut_a (
    .clk_i(clk), .reset_i(a_rst), .flush_i(a_fl),
    .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_id),
    .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od), .count_o(a_cnt)
  );

  pipe_elastic_stage #(.WIDTH(8), .DEPTH(4), .CLR_DATA(1'b1)) dut_b (
    .clk_i(clk), .reset_i(b_rst), .flush_i(b_fl),
    .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_id),
    .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od), .count_o(b_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1'b1; a_fl = 1'b0; a_iv = 1'b0; a_or = 1'b0; a_id = '0;
    b_rst = 1'b1; b_fl = 1'b0; b_iv = 1'b0; b_or = 1'b0; b_id = '0;

    // reset for 2 cycles with random inputs
    for (int c = 0; c < 2; c++) begin
      a_iv = 1'($urandom); a_or = 1'($urandom); a_fl = 1'($urandom); a_id = 8'($urandom);
      b_iv = 1'($urandom); b_or = 1'($urandom); b_id = 8'($urandom);
      tick;
    end
    a_rst = 1'b0; a_fl = 1'b0; a_iv = 1'b0; a_or = 1'b0;
    b_rst = 1'b0; b_iv = 1'b0; b_or = 1'b0;
    #1;
    chk("rst_ov",   a_ov,  0);
    chk("rst_cnt",  a_cnt, 0);
    chk("rst_data", a_od,  0);
    chk("rst_ir",   a_ir,  1);
    chk("rst_b_cnt", b_cnt, 0);

    // streaming 1..8, DEPTH=3
    a_or = 1'b1; a_iv = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      a_id = 8'(k);
      tick;
      if (k <= 2) chk("lat_ov", a_ov, 0);
      else begin
        chk("stream_ov",   a_ov,  1);
        chk("stream_data", a_od,  k - 2);
        chk("stream_cnt",  a_cnt, 3);
        chk("stream_ir",   a_ir,  1);
      end
    end
    a_iv = 1'b0;
    tick; chk("drain_7", a_od, 7); chk("drain_cnt2", a_cnt, 2);
    tick; chk("drain_8", a_od, 8); chk("drain_cnt1", a_cnt, 1);
    tick; chk("drain_ov", a_ov, 0); chk("drain_cnt0", a_cnt, 0);

    // back-pressure: fill with A,B,C then stall 5 cycles
    a_or = 1'b0; a_iv = 1'b1;
    a_id = 8'hA1; tick;
    a_id = 8'hB2; tick;
    a_id = 8'hC3; tick;
    chk("full_cnt", a_cnt, 3);
    a_id = 8'hD4;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ir",   a_ir,  0);
      chk("bp_data", a_od,  8'hA1);
      chk("bp_cnt",  a_cnt, 3);
      tick;
    end
    a_iv = 1'b0; a_or = 1'b1;
    #1; chk("bp_out_A", a_od, 8'hA1);
    tick; chk("bp_out_B", a_od, 8'hB2);
    tick; chk("bp_out_C", a_od, 8'hC3);
    tick; chk("bp_empty", a_ov, 0);

    // flush with 2 entries in flight and in_valid high
    a_or = 1'b0; a_iv = 1'b1;
    a_id = 8'h11; tick;
    a_id = 8'h22; tick;
    chk("fl_pre_cnt", a_cnt, 2);
    a_fl = 1'b1; a_id = 8'h77;
    #1; chk("fl_ir", a_ir, 0);
    tick;
    a_fl = 1'b0; a_iv = 1'b0;
    chk("fl_ov",  a_ov,  0);
    chk("fl_cnt", a_cnt, 0);
    chk("fl_data", a_od, 0);
    a_or = 1'b1;
    tick; tick; tick;
    chk("fl_no_accept", a_ov, 0);
    chk("fl_cnt_after", a_cnt, 0);

    // scoreboard: random handshakes, FIFO order and count tracked
    for (int c = 0; c < 300; c++) begin
      a_iv = ($urandom_range(0, 3) != 0);
      a_or = 1'($urandom);
      a_id = 8'($urandom);
      #1;
      if (a_ov && a_or) begin
        if (q.size() == 0) chk("sb_underflow", a_ov, 0);
        else begin
          chk("sb_data", a_od, q[0]);
          void'(q.pop_front());
        end
      end
      if (a_iv && a_ir) q.push_back(a_id);
      tick;
      chk("sb_count", a_cnt, q.size());
    end

    // bubble collapse, DEPTH=4
    b_or = 1'b0; b_iv = 1'b1; b_id = 8'h5A;
    tick;
    b_iv = 1'b0;
    tick; tick;
    chk("bub_ov_early", b_ov, 0);
    chk("bub_cnt_early", b_cnt, 1);
    tick;
    chk("bub_ov",   b_ov,  1);
    chk("bub_data", b_od,  8'h5A);
    chk("bub_cnt",  b_cnt, 1);
    chk("bub_ir",   b_ir,  1);
    b_iv = 1'b1;
    b_id = 8'h61; tick;
    b_id = 8'h62; tick;
    b_id = 8'h63; tick;
    chk("bub_full_cnt", b_cnt, 4);
    chk("bub_full_ir",  b_ir,  0);
    chk("bub_full_data", b_od, 8'h5A);

    // reset mid-stream while full and still pushing
    b_rst = 1'b1; b_or = 1'b1; b_id = 8'h99;
    tick;
    b_rst = 1'b0; b_iv = 1'b0;
    chk("mrst_ov",   b_ov,  0);
    chk("mrst_cnt",  b_cnt, 0);
    chk("mrst_data", b_od,  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
